// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver with a small first-word-fall-through receive FIFO.
// The serial input is brought into the clock domain by a two-flop
// synchroniser and sampled in the middle of every bit. Start bits that
// vanish before mid-bit are ignored. A low stop bit is a framing error.
// A frame that completes while the FIFO is full is dropped as an overrun.
//
// Optional feature: define UART_RX_PARITY_EN to expect a parity bit between
// the data bits and the stop bit. PARITY_ODD selects even (0) or odd (1)
// parity. Without the macro there is no parity bit and par_err is always 0.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   RX        in   asynchronous serial input, idle high
//   rd_en     in   pop the FIFO head (ignored while rdy = 0)
//   clr_err   in   clears the sticky error flags
//   rx_data   out  FIFO head data, zero while the FIFO is empty
//   rdy       out  FIFO not empty
//   fifo_cnt  out  FIFO occupancy
//   frm_err   out  sticky framing error (stop bit sampled low)
//   ovr_err   out  sticky overrun (frame completed while FIFO full)
//   par_err   out  sticky parity error
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int BAUD_DIV   = 2604,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          RX,
   input  logic                          rd_en,
   input  logic                          clr_err,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rdy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic                          frm_err,
   output logic                          ovr_err,
   output logic                          par_err
);

   localparam int CW   = $clog2(BAUD_DIV);
   localparam int BCW  = $clog2(DATA_BITS);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = PW + 1;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;
`endif

   logic                 sync1_q, sync2_q;
   logic                 rx_s;
   state_t               state_q, state_d;
   logic [CW-1:0]        baud_q, baud_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 sample;
   logic                 stop_sample;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic                 frm_q, frm_d;
   logic                 ovr_q, ovr_d;

   logic                 par_bad;
   logic                 frm_set, ovr_set, push_req, do_push, pop, full;

`ifdef UART_RX_PARITY_EN
   logic                 par_bit_q, par_bit_d;
   logic                 par_q, par_d;
   logic                 par_set;
`endif

   // Two-flop synchroniser. Both stages reset to the idle (high) level so a
   // reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= RX;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s   = sync2_q;
   assign sample = (baud_q == '0);

   // Receiver state register, baud counter, bit counter and shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
      end
   end

   // Next-state logic. Outside IDLE the baud counter always counts down;
   // each mid-bit sample (counter at zero) reloads it for the next bit.
   // The first load is half a bit so samples land in the bit centres.
   // Data bits arrive LSB first, so they are shifted in from the top.
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_d   = par_bit_q;
`endif
      if (state_q != S_IDLE) begin
         baud_d = baud_q - CW'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               baud_d  = CW'(BAUD_DIV / 2 - 1);
               state_d = S_START;
            end
         end
         S_START: begin
            if (sample) begin
               if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  baud_d    = CW'(BAUD_DIV - 1);
                  bit_cnt_d = '0;
                  state_d   = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (sample) begin
               shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
               baud_d    = CW'(BAUD_DIV - 1);
               bit_cnt_d = bit_cnt_q + BCW'(1);
               if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (sample) begin
               par_bit_d = rx_s;
               baud_d    = CW'(BAUD_DIV - 1);
               state_d   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (sample) begin
               stop_sample = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef UART_RX_PARITY_EN
   // Parity bit and parity error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_bit_q <= 1'b0;
         par_q     <= 1'b0;
      end else begin
         par_bit_q <= par_bit_d;
         par_q     <= par_d;
      end
   end

   // Data plus parity bit must XOR to the selected parity sense.
   assign par_bad = ((^shift_q) ^ par_bit_q) != 1'(PARITY_ODD);
   assign par_set = stop_sample & rx_s & par_bad;
   assign par_d   = par_set | (par_q & ~clr_err);
   assign par_err = par_q;
`else
   assign par_bad = 1'b0;
   assign par_err = 1'b0;
`endif

   // Frame disposition at the stop-bit sample. When the FIFO is full a
   // simultaneous pop frees a slot, so the frame is still accepted.
   assign full     = (cnt_q == CNTW'(FIFO_DEPTH));
   assign rdy      = (cnt_q != '0);
   assign pop      = rd_en & rdy;
   assign frm_set  = stop_sample & ~rx_s;
   assign push_req = stop_sample & rx_s & ~par_bad;
   assign ovr_set  = push_req & full & ~pop;
   assign do_push  = push_req & (~full | pop);

   // FIFO storage, pointers, occupancy and sticky frame/overrun flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         frm_q    <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         frm_q    <= frm_d;
         ovr_q    <= ovr_d;
      end
   end

   // Pointers wrap naturally because the depth is a power of two. A set
   // event wins over clr_err in the same cycle.
   always_comb begin
      mem_d = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = shift_q;
      end
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      cnt_d    = cnt_q + CNTW'(do_push) - CNTW'(pop);
      frm_d    = frm_set | (frm_q & ~clr_err);
      ovr_d    = ovr_set | (ovr_q & ~clr_err);
   end

   assign rx_data  = rdy ? mem_q[rd_ptr_q] : '0;
   assign fifo_cnt = cnt_q;
   assign frm_err  = frm_q;
   assign ovr_err  = ovr_q;

endmodule
